memory_bus_ctrl: RTL and testbench
==================================

# memory_bus_ctrl

Parametrised, handshaked memory-bus controller that sits between the CPU core and 2**BANK_BITS memory/peripheral banks. It decodes the top address bits to a bank, drives a one-hot bank strobe, and waits for a per-bank ready. This lets slow devices (SPI EEPROM, SPI RAM) stall the CPU while block RAM and registers answer in minimum latency. It returns read data and a one-cycle `done` pulse, and supports write-protected banks and an optional bus timeout.

## Interface
- ADDR_WIDTH, 16, CPU address width
- DATA_WIDTH, 8, data width
- BANK_BITS, 2, number of top address bits used as bank select; NUM_BANKS = 2**BANK_BITS
- READ_ONLY_MASK, 4'b0010, bit n set = bank n is read-only (default: bank 1 is ROM)
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort (used only with MEMORY_BUS_TIMEOUT_EN); must be ≥1

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- req  in  1  CPU access request, sampled only when `ready`=1
- write_enable  in  1  1 = write, 0 = read, sampled with req
- address  in  ADDR_WIDTH  CPU address, sampled with req
- data_in  in  DATA_WIDTH  write data, sampled with req
- data_out  out  DATA_WIDTH  read data, registered; reset 0
- ready  out  1  controller idle, can accept req; reset 1
- done  out  1  one-cycle completion pulse; reset 0
- error  out  1  last access timed out; reset 0
- bank_enable  out  NUM_BANKS  one-hot bank strobe; reset 0
- bank_write_enable  out  NUM_BANKS  one-hot write qualifier; reset 0
- bank_address  out  ADDR_WIDTH-BANK_BITS  latched low address bits; reset 0
- bank_data_in  out  DATA_WIDTH  latched write data, common to all banks; reset 0
- bank_data_out  in  NUM_BANKS*DATA_WIDTH  bank n read data at bits [n*DATA_WIDTH +: DATA_WIDTH]
- bank_ready  in  NUM_BANKS  bank n access complete; tie high for zero-wait banks

## Operation
- States: IDLE, WAIT, PROT.
- IDLE (`ready`=1): on req, latch address, data, and direction. bank = address[ADDR_WIDTH-1 -: BANK_BITS]. Clear `error`, load timeout counter with 0.
  - Write to a bank with its READ_ONLY_MASK bit set: no strobe, go to PROT.
  - Otherwise: set bank_enable[bank]=1 and bank_write_enable[bank]=write_enable, go to WAIT.
- WAIT: hold strobes, `bank_address`, and `bank_data_in` stable. Only bank_ready[bank] of the selected bank is observed; all others are ignored.
  - When it is 1: on reads, register the bank's slice into `data_out`. Clear strobes, pulse `done`, go to IDLE.
  - Otherwise increment the counter.
- PROT: pulse `done`, go to IDLE. The write is dropped; `error` is not set and `data_out` is unchanged.
- `data_out` changes only on read completion. Writes and timeouts without the macro leave it unchanged.
- req while `ready`=0 is ignored; the CPU must hold or re-issue it.
- `done` is asserted in the same cycle the state returns to IDLE (`ready`=1). A req in that cycle is accepted, giving back-to-back operation.
- Reset at any time, including mid-WAIT, forces IDLE and all reset values immediately. It drops strobes; an in-flight bank transaction is abandoned.

## Timing
- Req sampled at edge 0 → bank_enable high from edge 0 to edge N.
- Ready bank (bank_ready=1 at edge 1) → `done`/`data_out` valid after edge 1. Minimum latency is 2 cycles from req to done; throughput is 1 access per 2 cycles.
- A bank asserting ready k cycles late adds k cycles.
- Read-only write: `done` one cycle after req acceptance, with no strobe ever asserted.
- Timeout counter width $clog2(TIMEOUT_CYCLES+1) with no wrap: it saturates and aborts at TIMEOUT_CYCLES.

## Configuration
- MEMORY_BUS_TIMEOUT_EN defined: in WAIT, if the counter reaches TIMEOUT_CYCLES with bank_ready still 0:
  - Drop strobes, set `data_out` to all ones (reads only), set `error`=1, pulse `done`, go to IDLE.
  - `error` holds until the next accepted req.
  - bank_ready and timeout in the same cycle: ready wins, normal completion with no error.
- Undefined: WAIT lasts indefinitely; `error` is constant 0; no counter is synthesised.

## Test plan
- Defaults, bank 3 ready tied 1, read 0xC005 with bank 3 data 0x5A → bank_enable=4'b1000 one cycle, bank_address=0x0005, done 2 cycles after req, data_out=0x5A.
- Write 0x0010 data 0xA7, bank 0 ready after 3 wait cycles → bank_enable[0] and bank_write_enable[0] high 4 cycles, bank_data_in=0xA7, done on cycle 5, data_out unchanged.
- Write 0x4000 data 0x11 (read-only bank 1) → no strobe, done 2 cycles after req, error=0; a subsequent read of 0x4000 returns bank 1 data.
- MEMORY_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, read of bank 2 with ready held 0 → done after 4 WAIT cycles, data_out=0xFF, error=1, cleared on next req.
- Reset asserted during WAIT of a 10-cycle bank → all strobes 0 and ready=1 asynchronously. After release, a read of a zero-wait bank completes normally in 2 cycles.
- Back-to-back reads of 0x8001 then 0xC002 with req asserted in each done cycle → two done pulses 2 cycles apart, correct data each.

Source files
------------

// File: rtl/memory_bus_ctrl.sv
// memory_bus_ctrl
//   Handshaked controller between the CPU core and 2**BANK_BITS memory or
//   peripheral banks. The top BANK_BITS address bits pick a bank, which gets
//   a one-hot strobe held until that bank raises its ready. Writes to
//   read-only banks are dropped without strobing. Every access ends with a
//   one-cycle done pulse.
//
//   Optional feature: define MEMORY_BUS_TIMEOUT_EN to abort accesses that
//   wait TIMEOUT_CYCLES cycles without a ready. An aborted read returns all
//   ones and the access sets error.
//
// Ports
//   clk, reset           clock and asynchronous active-high reset
//   req, write_enable    CPU request and direction, sampled while ready=1
//   address, data_in     CPU address and write data, sampled with req
//   data_out             registered read data
//   ready, done, error   idle flag, completion pulse, last-access-timed-out
//   bank_enable          one-hot bank strobe
//   bank_write_enable    one-hot write qualifier
//   bank_address         latched low address bits
//   bank_data_in         latched write data, shared by all banks
//   bank_data_out        packed read data, bank n at [n*DATA_WIDTH +: DATA_WIDTH]
//   bank_ready           per-bank access complete
module memory_bus_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BANK_BITS = 2,
    parameter logic [(2**BANK_BITS)-1:0] READ_ONLY_MASK = 4'b0010,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req,
    input  logic                                 write_enable,
    input  logic [ADDR_WIDTH-1:0]                address,
    input  logic [DATA_WIDTH-1:0]                data_in,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic                                 ready,
    output logic                                 done,
    output logic                                 error,
    output logic [(2**BANK_BITS)-1:0]            bank_enable,
    output logic [(2**BANK_BITS)-1:0]            bank_write_enable,
    output logic [ADDR_WIDTH-BANK_BITS-1:0]      bank_address,
    output logic [DATA_WIDTH-1:0]                bank_data_in,
    input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0] bank_data_out,
    input  logic [(2**BANK_BITS)-1:0]            bank_ready
);

    localparam int unsigned NB = 2**BANK_BITS;

    typedef enum logic [1:0] {StIdle, StWait, StProt} state_e;

    state_e                 state_q;
    logic [BANK_BITS-1:0]   bank_q;
    logic                   we_q;

    logic [BANK_BITS-1:0]   req_bank;
    logic                   sel_ready;
    logic [DATA_WIDTH-1:0]  sel_data;

    assign req_bank  = address[ADDR_WIDTH-1 -: BANK_BITS];
    // Only the selected bank's ready and data are ever looked at.
    assign sel_ready = bank_ready[bank_q];
    assign sel_data  = bank_data_out[bank_q * DATA_WIDTH +: DATA_WIDTH];

`ifdef MEMORY_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;

    // Abort on the cycle the wait count would reach TIMEOUT_CYCLES.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= StIdle;
            bank_q            <= '0;
            we_q              <= 1'b0;
            data_out          <= '0;
            ready             <= 1'b1;
            done              <= 1'b0;
            bank_enable       <= '0;
            bank_write_enable <= '0;
            bank_address      <= '0;
            bank_data_in      <= '0;
`ifdef MEMORY_BUS_TIMEOUT_EN
            error             <= 1'b0;
            cnt_q             <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        bank_q       <= req_bank;
                        we_q         <= write_enable;
                        bank_address <= address[ADDR_WIDTH-BANK_BITS-1:0];
                        bank_data_in <= data_in;
                        ready        <= 1'b0;
`ifdef MEMORY_BUS_TIMEOUT_EN
                        error        <= 1'b0;
                        cnt_q        <= '0;
`endif
                        if (write_enable && READ_ONLY_MASK[req_bank]) begin
                            state_q <= StProt;
                        end else begin
                            bank_enable       <= NB'(1) << req_bank;
                            bank_write_enable <= write_enable ? (NB'(1) << req_bank) : '0;
                            state_q           <= StWait;
                        end
                    end
                end
                StWait: begin
                    // Ready has priority over a timeout in the same cycle.
                    if (sel_ready) begin
                        if (!we_q) begin
                            data_out <= sel_data;
                        end
                        bank_enable       <= '0;
                        bank_write_enable <= '0;
                        done              <= 1'b1;
                        ready             <= 1'b1;
                        state_q           <= StIdle;
                    end
`ifdef MEMORY_BUS_TIMEOUT_EN
                    else if (timeout_hit) begin
                        if (!we_q) begin
                            data_out <= '1;
                        end
                        bank_enable       <= '0;
                        bank_write_enable <= '0;
                        error             <= 1'b1;
                        done              <= 1'b1;
                        ready             <= 1'b1;
                        state_q           <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                StProt: begin
                    done    <= 1'b1;
                    ready   <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_ctrl.sv
module tb_memory_bus_ctrl;

    localparam int TMO = 4;
`ifdef MEMORY_BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [3:0] RO_MASK = 4'b0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        write_enable = 1'b0;
    logic [15:0] address = '0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        ready, done, error;
    logic [3:0]  bank_enable, bank_write_enable;
    logic [13:0] bank_address;
    logic [7:0]  bank_data_in;
    logic [31:0] bank_data_out;
    logic [3:0]  bank_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    memory_bus_ctrl #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .BANK_BITS(2),
        .READ_ONLY_MASK(4'b0010),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .write_enable(write_enable),
        .address(address),
        .data_in(data_in),
        .data_out(data_out),
        .ready(ready),
        .done(done),
        .error(error),
        .bank_enable(bank_enable),
        .bank_write_enable(bank_write_enable),
        .bank_address(bank_address),
        .bank_data_in(bank_data_in),
        .bank_data_out(bank_data_out),
        .bank_ready(bank_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural banks: a small memory each, ready after lat[n] strobed edges.
    logic [7:0] mem [4][16];
    int         lat [4];
    int         wcnt [4];

    function automatic logic [7:0] pat(input int n, input int i);
        if (n == 3 && i == 5) return 8'h5A;
        if (n == 1 && i == 0) return 8'h3C;
        if (n == 2 && i == 1) return 8'hC3;
        if (n == 3 && i == 2) return 8'hE7;
        return 8'((n * 16 + i) ^ 8'h96);
    endfunction

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            wcnt[n] <= bank_enable[n] ? wcnt[n] + 1 : 0;
            if (reset) begin
                for (int i = 0; i < 16; i++) mem[n][i] <= pat(n, i);
            end else if (bank_enable[n] && bank_write_enable[n] && bank_ready[n]) begin
                mem[n][bank_address[3:0]] <= bank_data_in;
            end
        end
    end

    always_comb begin
        bank_data_out = '0;
        bank_ready    = '0;
        for (int n = 0; n < 4; n++) begin
            bank_data_out[n*8 +: 8] = mem[n][bank_address[3:0]];
            bank_ready[n]           = (wcnt[n] >= lat[n]);
        end
    end

    // Transaction-level reference state.
    logic [7:0] ref_mem [4][16];
    logic [7:0] ref_dout;
    logic       ref_err;

    task automatic reset_model();
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 16; i++) ref_mem[n][i] = pat(n, i);
        ref_dout = 8'h00;
        ref_err  = 1'b0;
    endtask

    // Predicts edges-after-acceptance to done, strobes and end state.
    task automatic predict(input logic we, input logic [15:0] a, input logic [7:0] wd,
                           input int l, output int exp_d, output logic [3:0] exp_en,
                           output logic [3:0] exp_wen);
        int b;
        b = int'(a[15:14]);
        ref_err = 1'b0;
        if (we && RO_MASK[b]) begin
            exp_d   = 1;
            exp_en  = 4'b0000;
            exp_wen = 4'b0000;
        end else begin
            exp_en  = 4'(1 << b);
            exp_wen = we ? exp_en : 4'b0000;
            if (TMO_EN && l >= TMO) begin
                exp_d   = TMO;
                ref_err = 1'b1;
                if (!we) ref_dout = 8'hFF;
            end else begin
                exp_d = l + 1;
                if (we) ref_mem[b][a[3:0]] = wd;
                else ref_dout = ref_mem[b][a[3:0]];
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic do_txn(input string name, input logic we, input logic [15:0] a,
                          input logic [7:0] wd, input int l, output int d,
                          output logic [3:0] en, output logic [3:0] wen,
                          output logic [13:0] ba, output logic [7:0] bdi);
        int  waits;
        bit  stable;
        waits = 0;
        while (!ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 100) check({name, "_ready_wait"}, 32'(waits), 0);
        lat[a[15:14]] = l;
        req = 1'b1;
        write_enable = we;
        address = a;
        data_in = wd;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        en  = bank_enable;
        wen = bank_write_enable;
        ba  = bank_address;
        bdi = bank_data_in;
        check({name, "_err_clr"}, 32'(error), 0);
        check({name, "_busy"}, 32'(ready), 0);
        stable = 1'b1;
        d = 0;
        while (!done && d < 60) begin
            @(posedge clk);
            d++;
            @(negedge clk);
            if (!done && (bank_enable != en || bank_write_enable != wen || bank_address != ba))
                stable = 1'b0;
        end
        check({name, "_stable"}, 32'(stable), 1);
        check({name, "_ready_at_done"}, 32'(ready), 1);
        check({name, "_strobe_drop"}, 32'(bank_enable), 0);
    endtask

    typedef struct {
        logic       we;
        logic [15:0] a;
        logic [7:0] wd;
        int         lat;
        int         exp_d;
        logic [3:0] exp_en;
        logic [3:0] exp_wen;
        logic [7:0] exp_dout;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int d, ed, d1, c1;
        logic [3:0] en, wen, een, ewen;
        logic [13:0] ba;
        logic [7:0] bdi;

        // exp_d counts clock edges from acceptance to the done edge.
        vecs[0] = '{1'b0, 16'hC005, 8'h00, 0, 1, 4'b1000, 4'b0000, 8'h5A, 1'b0};
        vecs[1] = '{1'b1, 16'h0010, 8'hA7, 3, 4, 4'b0001, 4'b0001, 8'h5A, 1'b0};
        vecs[2] = '{1'b1, 16'h4000, 8'h11, 0, 1, 4'b0000, 4'b0000, 8'h5A, 1'b0};
        vecs[3] = '{1'b0, 16'h4000, 8'h00, 0, 1, 4'b0010, 4'b0000, 8'h3C, 1'b0};
        vecs[4] = '{1'b0, 16'h0010, 8'h00, 1, 2, 4'b0001, 4'b0000, 8'hA7, 1'b0};
        vecs[5] = '{1'b0, 16'h8001, 8'h00, 2, 3, 4'b0100, 4'b0000, 8'hC3, 1'b0};
        vecs[6] = '{1'b1, 16'hC002, 8'h99, 0, 1, 4'b1000, 4'b1000, 8'hC3, 1'b0};

        for (int n = 0; n < 4; n++) lat[n] = 0;
        reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_dout", 32'(data_out), 0);
        check("rst_en", 32'(bank_enable), 0);
        check("rst_wen", 32'(bank_write_enable), 0);
        check("rst_baddr", 32'(bank_address), 0);
        check("rst_bdin", 32'(bank_data_in), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            predict(vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].lat, ed, een, ewen);
            do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].lat,
                   d, en, wen, ba, bdi);
            check($sformatf("vec%0d_lat", i), 32'(d), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d_en", i), 32'(en), 32'(vecs[i].exp_en));
            check($sformatf("vec%0d_wen", i), 32'(wen), 32'(vecs[i].exp_wen));
            check($sformatf("vec%0d_baddr", i), 32'(ba), 32'(vecs[i].a[13:0]));
            check($sformatf("vec%0d_bdin", i), 32'(bdi), 32'(vecs[i].wd));
            check($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_err", i), 32'(error), 32'(vecs[i].exp_err));
        end
        check("rom_untouched", 32'(mem[1][0]), 32'h3C);
        check("wr_landed", 32'(mem[3][2]), 32'h99);

        // Back-to-back reads issued in each done cycle.
        predict(1'b0, 16'h8001, 8'h00, 0, ed, een, ewen);
        do_txn("b2b0", 1'b0, 16'h8001, 8'h00, 0, d, en, wen, ba, bdi);
        c1 = cyc;
        check("b2b0_dout", 32'(data_out), 32'hC3);
        predict(1'b0, 16'hC005, 8'h00, 0, ed, een, ewen);
        do_txn("b2b1", 1'b0, 16'hC005, 8'h00, 0, d1, en, wen, ba, bdi);
        check("b2b1_dout", 32'(data_out), 32'h5A);
        check("b2b_gap", 32'(cyc - c1), 2);

`ifdef MEMORY_BUS_TIMEOUT_EN
        predict(1'b0, 16'h8002, 8'h00, 1000, ed, een, ewen);
        do_txn("tmo", 1'b0, 16'h8002, 8'h00, 1000, d, en, wen, ba, bdi);
        check("tmo_lat", 32'(d), TMO);
        check("tmo_dout", 32'(data_out), 32'hFF);
        check("tmo_err", 32'(error), 1);
        @(negedge clk);
        check("tmo_err_hold", 32'(error), 1);
        predict(1'b0, 16'hC005, 8'h00, 0, ed, een, ewen);
        do_txn("tmo_next", 1'b0, 16'hC005, 8'h00, 0, d, en, wen, ba, bdi);
        check("tmo_next_err", 32'(error), 0);
        check("tmo_next_dout", 32'(data_out), 32'h5A);
`endif

        // Randomized traffic against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            logic we;
            logic [15:0] a;
            logic [7:0] wd;
            int l;
            we = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            wd = 8'($urandom);
            l  = $urandom_range(0, 6);
            if (TMO_EN && $urandom_range(0, 7) == 0) l = 1000;
            predict(we, a, wd, l, ed, een, ewen);
            do_txn($sformatf("rnd%0d", i), we, a, wd, l, d, en, wen, ba, bdi);
            check($sformatf("rnd%0d_lat", i), 32'(d), 32'(ed));
            check($sformatf("rnd%0d_en", i), 32'(en), 32'(een));
            check($sformatf("rnd%0d_wen", i), 32'(wen), 32'(ewen));
            check($sformatf("rnd%0d_baddr", i), 32'(ba), 32'(a[13:0]));
            check($sformatf("rnd%0d_dout", i), 32'(data_out), 32'(ref_dout));
            check($sformatf("rnd%0d_err", i), 32'(error), 32'(ref_err));
        end

        // Reset in the middle of a long wait.
        lat[2] = 10;
        req = 1'b1;
        write_enable = 1'b0;
        address = 16'h8003;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_wait_en", 32'(bank_enable), 32'b0100);
        #2 reset = 1'b1;
        #1;
        check("arst_en", 32'(bank_enable), 0);
        check("arst_ready", 32'(ready), 1);
        check("arst_done", 32'(done), 0);
        check("arst_dout", 32'(data_out), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        reset_model();
        @(negedge clk);
        predict(1'b0, 16'hC005, 8'h00, 0, ed, een, ewen);
        do_txn("post_rst", 1'b0, 16'hC005, 8'h00, 0, d, en, wen, ba, bdi);
        check("post_rst_lat", 32'(d), 1);
        check("post_rst_en", 32'(en), 32'b1000);
        check("post_rst_dout", 32'(data_out), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
